uart_rx_param: RTL



---
 rtl/uart_rx_param.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority vote per bit, optional parity,
// 1 or 2 stop bits, parity/framing/overrun flags and a valid/ready output.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD;
  localparam int unsigned HALF      = BIT_TICKS / 2;
  localparam int unsigned CW        = $clog2(BIT_TICKS) + 1;

  localparam logic [CW-1:0] CNT_S0    = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1    = CW'(HALF);
  localparam logic [CW-1:0] CNT_VOTE  = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_TICKS - 1);
  localparam logic [3:0]    IDX_DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    IDX_SLAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 fe_q, fe_d;
  logic                 arm_q, arm_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 maj, at_vote, at_last, complete;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    smp_d        = smp_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    fe_d         = fe_q;
    arm_d        = arm_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    complete     = 1'b0;

    maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    at_vote = (cnt_q == CNT_VOTE);
    at_last = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
      if (cnt_q == CNT_S0) smp_d[0] = rx_s_q;
      if (cnt_q == CNT_S1) smp_d[1] = rx_s_q;
    end

    case (state_q)
      S_IDLE: begin
        // A start needs the line to have been seen high since the last frame,
        // so a held break does not retrigger.
        arm_d = arm_q | rx_s_q;
        if (!rx_s_q && arm_q) begin
          state_d = S_START;
          cnt_d   = CW'(1);
          arm_d   = 1'b0;
          fe_d    = 1'b0;
          par_d   = 1'b0;
        end
      end
      S_START: begin
        if (at_vote && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (at_last) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (at_vote) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (at_last) begin
          if (idx_q == IDX_DLAST) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (at_vote) par_d = (^shreg_q) ^ maj ^ (PARITY == 1);
        if (at_last) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (at_vote) begin
          if (!maj) fe_d = 1'b1;
          if (idx_q == IDX_SLAST) begin
            complete = 1'b1;
            state_d  = S_IDLE;
            cnt_d    = '0;
          end
        end else if (at_last) begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (complete) begin
      out_data_d   = shreg_q;
      out_valid_d  = 1'b1;
      parity_err_d = par_q & (PARITY != 0);
      frame_err_d  = fe_q | ~maj;
      overrun_d    = out_valid_q & ~out_ready;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      smp_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      fe_q         <= 1'b0;
      arm_q        <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      smp_q        <= smp_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      fe_q         <= fe_d;
      arm_q        <= arm_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule
